// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// slave: the scheduler (consumes hazards, drives stall/flush); master: the pipeline.
interface hazard_ctrl_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic        EX_MemRead;
    logic [4:0]  EX_Dst;
    logic        ID_MulDivStart;
    logic        ID_HiLoAccess;
    logic        ID_Eret;
    logic        EX_BLCancel;
    logic        MEM_Exception;
    logic        IF_MemBusy;
    logic        MEM_MemBusy;
    logic        IF_Stall;
    logic        ID_Stall;
    logic        EX_Stall;
    logic        MEM_Stall;
    logic        IF_Flush;
    logic        ID_Flush;
    logic        EX_Flush;
    logic        PC_SelVector;
    logic        MulDivBusy;
    logic [31:0] StallCount;

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_Dst, ID_MulDivStart,
               ID_HiLoAccess, ID_Eret, EX_BLCancel, MEM_Exception, IF_MemBusy, MEM_MemBusy,
        output IF_Stall, ID_Stall, EX_Stall, MEM_Stall, IF_Flush, ID_Flush, EX_Flush,
               PC_SelVector, MulDivBusy, StallCount
    );

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_Dst, ID_MulDivStart,
               ID_HiLoAccess, ID_Eret, EX_BLCancel, MEM_Exception, IF_MemBusy, MEM_MemBusy,
        input  IF_Stall, ID_Stall, EX_Stall, MEM_Stall, IF_Flush, ID_Flush, EX_Flush,
               PC_SelVector, MulDivBusy, StallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline with mult/div busy counter and
// exception-flush FSM. Define HAZ_PERF_CNT_EN to enable the ID stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 6
) (
    input  logic          CLK,
    input  logic          RST_N,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [0:0] {StRun, StExcHold} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_busy;
    logic w_lu;
    logic w_hl;
    logic w_take;
    logic w_load;
    logic w_if_stall;
    logic w_id_stall;
    logic w_ex_stall;
    logic w_mem_stall;
    logic w_if_flush;
    logic w_id_flush;
    logic w_ex_flush;
    logic w_pc_vec;

    assign w_busy = (r_cnt != '0);

    assign w_lu = hz.EX_MemRead && (hz.EX_Dst != 5'd0) &&
                  ((hz.ID_UsesRs && (hz.ID_Rs == hz.EX_Dst)) ||
                   (hz.ID_UsesRt && (hz.ID_Rt == hz.EX_Dst)));

    assign w_hl   = hz.ID_HiLoAccess & w_busy;
    // An exception waits until MEM is no longer busy so the faulting access is settled.
    assign w_take = hz.MEM_Exception & ~hz.MEM_MemBusy;

    always_comb begin
        w_mem_stall = hz.MEM_MemBusy;
        w_ex_stall  = w_mem_stall;
        w_id_stall  = w_ex_stall | w_lu | w_hl;
        w_if_stall  = w_id_stall | hz.IF_MemBusy;
        w_if_flush  = hz.EX_BLCancel | (hz.ID_Eret & ~w_id_stall);
        w_id_flush  = w_id_stall & ~w_ex_stall;
        w_ex_flush  = 1'b0;
        w_pc_vec    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            StRun: begin
                if (w_take) begin
                    w_pc_vec    = 1'b1;
                    w_if_flush  = 1'b1;
                    w_id_flush  = 1'b1;
                    w_ex_flush  = 1'b1;
                    w_mem_stall = 1'b0;
                    w_ex_stall  = 1'b0;
                    w_id_stall  = 1'b0;
                    w_if_stall  = hz.IF_MemBusy;
                    w_state_nxt = StExcHold;
                end
            end
            StExcHold: begin
                // Squash whatever is fetched until the vector fetch completes.
                w_if_flush = 1'b1;
                w_id_flush = 1'b0;
                w_ex_flush = 1'b0;
                if (!hz.IF_MemBusy) begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    assign w_load = hz.ID_MulDivStart & ~w_id_stall & (r_state == StRun) & ~hz.MEM_Exception;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_load) begin
            w_cnt_nxt = CNT_W'(MULDIV_CYCLES);
        end else if (w_busy) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Combinational outputs are forced low for the whole time reset is held.
    assign hz.IF_Stall     = RST_N & w_if_stall;
    assign hz.ID_Stall     = RST_N & w_id_stall;
    assign hz.EX_Stall     = RST_N & w_ex_stall;
    assign hz.MEM_Stall    = RST_N & w_mem_stall;
    assign hz.IF_Flush     = RST_N & w_if_flush;
    assign hz.ID_Flush     = RST_N & w_id_flush;
    assign hz.EX_Flush     = RST_N & w_ex_flush;
    assign hz.PC_SelVector = RST_N & w_pc_vec;
    assign hz.MulDivBusy   = w_busy;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
        end else if (w_id_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign hz.StallCount = r_stall_cnt;
`else
    assign hz.StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of the scheduling rules.
module tb_hazard_ctrl;

    localparam int unsigned N = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    hazard_ctrl_if u_if ();

    hazard_ctrl #(
        .MULDIV_CYCLES (N),
        .CNT_W         (6)
    ) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .hz    (u_if)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: cycles of HI/LO occupancy left, exception-hold flag, ID stall tally.
    int     m_busy_left = 0;
    bit     m_hold      = 1'b0;
    longint m_stalls    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] got_vec();
        return {u_if.IF_Stall, u_if.ID_Stall, u_if.EX_Stall, u_if.MEM_Stall, u_if.IF_Flush,
                u_if.ID_Flush, u_if.EX_Flush, u_if.PC_SelVector, u_if.MulDivBusy};
    endfunction

    // {if_st, id_st, ex_st, mem_st, if_fl, id_fl, ex_fl, pc_vec, busy}
    function automatic logic [8:0] model_out();
        bit lu, hl, busy, take;
        bit if_st, id_st, ex_st, mem_st, if_fl, id_fl, ex_fl, pc;
        if (!RST_N) return 9'd0;
        busy = (m_busy_left > 0);
        lu = u_if.EX_MemRead && u_if.EX_Dst != 0 &&
             ((u_if.ID_UsesRs && u_if.ID_Rs == u_if.EX_Dst) ||
              (u_if.ID_UsesRt && u_if.ID_Rt == u_if.EX_Dst));
        hl   = u_if.ID_HiLoAccess && busy;
        take = !m_hold && u_if.MEM_Exception && !u_if.MEM_MemBusy;
        if (take) begin
            {mem_st, ex_st, id_st} = 3'b000;
            if_st = u_if.IF_MemBusy;
            {if_fl, id_fl, ex_fl, pc} = 4'b1111;
        end else begin
            mem_st = u_if.MEM_MemBusy;
            ex_st  = mem_st;
            id_st  = ex_st || lu || hl;
            if_st  = id_st || u_if.IF_MemBusy;
            pc     = 1'b0;
            ex_fl  = 1'b0;
            if (m_hold) begin
                if_fl = 1'b1;
                id_fl = 1'b0;
            end else begin
                if_fl = u_if.EX_BLCancel || (u_if.ID_Eret && !id_st);
                id_fl = id_st && !ex_st;
            end
        end
        return {if_st, id_st, ex_st, mem_st, if_fl, id_fl, ex_fl, pc, busy};
    endfunction

    // Compare process: every falling edge, DUT against model, then advance the model.
    always @(negedge CLK) begin
        logic [8:0]  e;
        logic [31:0] sc_exp;
        if (!RST_N) begin
            m_busy_left = 0;
            m_hold      = 1'b0;
            m_stalls    = 0;
        end
        e = model_out();
        check("cycle_outputs", {55'd0, got_vec()}, {55'd0, e});
`ifdef HAZ_PERF_CNT_EN
        sc_exp = m_stalls[31:0];
`else
        sc_exp = 32'd0;
`endif
        check("stall_count", {32'd0, u_if.StallCount}, {32'd0, sc_exp});
        if (RST_N) begin
            if (!m_hold && u_if.ID_MulDivStart && !e[7] && !u_if.MEM_Exception)
                m_busy_left = N;
            else if (m_busy_left > 0)
                m_busy_left = m_busy_left - 1;
            if (e[7] && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (e[1]) m_hold = 1'b1;
            else if (m_hold && !u_if.IF_MemBusy) m_hold = 1'b0;
        end
    end

    task automatic idle();
        u_if.ID_Rs = 5'd0; u_if.ID_Rt = 5'd0; u_if.ID_UsesRs = 1'b0; u_if.ID_UsesRt = 1'b0;
        u_if.EX_MemRead = 1'b0; u_if.EX_Dst = 5'd0; u_if.ID_MulDivStart = 1'b0;
        u_if.ID_HiLoAccess = 1'b0; u_if.ID_Eret = 1'b0; u_if.EX_BLCancel = 1'b0;
        u_if.MEM_Exception = 1'b0; u_if.IF_MemBusy = 1'b0; u_if.MEM_MemBusy = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    initial begin
        idle();
        u_if.IF_MemBusy  = 1'b1;
        u_if.EX_BLCancel = 1'b1;
        #3;
        check("reset_all_zero", {55'd0, got_vec()}, 64'd0);
        check("reset_stallcount", {32'd0, u_if.StallCount}, 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        idle();
        RST_N = 1'b1;
        sample();
        check("post_reset_busy", {63'd0, u_if.MulDivBusy}, 64'd0);

        // Load-use on rs
        step(); idle();
        u_if.EX_MemRead = 1'b1; u_if.EX_Dst = 5'd5; u_if.ID_Rs = 5'd5; u_if.ID_UsesRs = 1'b1;
        sample();
        check("lu_id_stall", {63'd0, u_if.ID_Stall}, 64'd1);
        check("lu_if_stall", {63'd0, u_if.IF_Stall}, 64'd1);
        check("lu_id_flush", {63'd0, u_if.ID_Flush}, 64'd1);
        check("lu_ex_stall", {63'd0, u_if.EX_Stall}, 64'd0);
        step();
        u_if.EX_Dst = 5'd0; u_if.ID_Rs = 5'd0;
        sample();
        check("lu_r0_no_stall", {63'd0, u_if.ID_Stall}, 64'd0);

        // Mult/div issue at cycle 0, MFLO from cycle 2
        step(); idle(); u_if.ID_MulDivStart = 1'b1;
        sample();
        check("md_c0_busy", {63'd0, u_if.MulDivBusy}, 64'd0);
        step(); idle();
        sample();
        check("md_c1_busy", {63'd0, u_if.MulDivBusy}, 64'd1);
        for (int c = 2; c <= 5; c++) begin
            step(); idle(); u_if.ID_HiLoAccess = 1'b1;
            sample();
            check($sformatf("md_c%0d_busy", c), {63'd0, u_if.MulDivBusy}, (c < 5) ? 64'd1 : 64'd0);
            check($sformatf("md_c%0d_stall", c), {63'd0, u_if.ID_Stall}, (c < 5) ? 64'd1 : 64'd0);
        end

        // Exception taken, then vector fetch busy for two cycles
        step(); idle(); u_if.MEM_Exception = 1'b1;
        sample();
        check("exc_pc_vec", {63'd0, u_if.PC_SelVector}, 64'd1);
        check("exc_flushes", {61'd0, u_if.IF_Flush, u_if.ID_Flush, u_if.EX_Flush}, 64'd7);
        check("exc_no_id_stall", {63'd0, u_if.ID_Stall}, 64'd0);
        for (int c = 0; c < 2; c++) begin
            step(); idle(); u_if.IF_MemBusy = 1'b1;
            sample();
            check("hold_if_flush", {63'd0, u_if.IF_Flush}, 64'd1);
            check("hold_pc_vec", {63'd0, u_if.PC_SelVector}, 64'd0);
        end
        step(); idle();
        step(); idle();
        sample();
        check("hold_exit_if_flush", {63'd0, u_if.IF_Flush}, 64'd0);

        // Memory stall with a pending exception
        for (int c = 0; c < 3; c++) begin
            step(); idle(); u_if.MEM_MemBusy = 1'b1; u_if.MEM_Exception = 1'b1;
            sample();
            check("mstall_chain", {60'd0, u_if.MEM_Stall, u_if.EX_Stall, u_if.ID_Stall,
                                   u_if.IF_Stall}, 64'hF);
            check("mstall_no_bubble", {62'd0, u_if.ID_Flush, u_if.PC_SelVector}, 64'd0);
        end
        step(); idle(); u_if.MEM_Exception = 1'b1;
        sample();
        check("mstall_exc_taken", {63'd0, u_if.PC_SelVector}, 64'd1);
        step(); idle();

        // ERET and branch-likely cancel
        step(); idle(); u_if.ID_Eret = 1'b1;
        sample();
        check("eret_if_flush", {62'd0, u_if.IF_Flush, u_if.IF_Stall}, 64'd2);
        step(); idle(); u_if.EX_BLCancel = 1'b1; u_if.IF_MemBusy = 1'b1;
        sample();
        check("bl_if_flush_stall", {62'd0, u_if.IF_Flush, u_if.IF_Stall}, 64'd3);

        // Asynchronous reset while busy and in exception hold
        step(); idle(); u_if.ID_MulDivStart = 1'b1;
        step(); idle(); u_if.MEM_Exception = 1'b1;
        step(); idle(); u_if.IF_MemBusy = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_zero", {55'd0, got_vec()}, 64'd0);
        sample();
        step(); idle(); RST_N = 1'b1;
        sample();
        check("rst_release_run", {62'd0, u_if.IF_Flush, u_if.MulDivBusy}, 64'd0);

        // Randomized run; the compare process does the checking
        for (int i = 0; i < 3000; i++) begin
            step();
            u_if.ID_Rs          = 5'($urandom_range(0, 3));
            u_if.ID_Rt          = 5'($urandom_range(0, 3));
            u_if.ID_UsesRs      = 1'($urandom_range(0, 1));
            u_if.ID_UsesRt      = 1'($urandom_range(0, 1));
            u_if.EX_MemRead     = 1'($urandom_range(0, 1));
            u_if.EX_Dst         = 5'($urandom_range(0, 3));
            u_if.ID_MulDivStart = ($urandom_range(0, 3) == 0);
            u_if.ID_HiLoAccess  = ($urandom_range(0, 2) == 0);
            u_if.ID_Eret        = ($urandom_range(0, 7) == 0);
            u_if.EX_BLCancel    = ($urandom_range(0, 7) == 0);
            u_if.MEM_Exception  = ($urandom_range(0, 9) == 0);
            u_if.IF_MemBusy     = ($urandom_range(0, 2) == 0);
            u_if.MEM_MemBusy    = ($urandom_range(0, 3) == 0);
        end
        sample();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline. It computes the per-stage stall and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from hazard inputs:
- load-use interlock
- memory busy
- multiply/divide occupancy
- branch-likely cancel
- ERET delay slot
- exceptions

It owns the mult/div busy counter and a small exception-flush FSM.

Parameters:
MULDIV_CYCLES, 32, cycles a mult/div occupies HI/LO after issue (1..63)
CNT_W, 6, width of mult/div busy counter (must hold MULDIV_CYCLES)

Ports:
CLK  in  1  clock
RST_N  in  1  reset, asynchronous, active-low
ID_Rs  in  5  rs field of instruction in ID
ID_Rt  in  5  rt field of instruction in ID
ID_UsesRs  in  1  ID instruction reads rs
ID_UsesRt  in  1  ID instruction reads rt
EX_MemRead  in  1  instruction in EX is a load
EX_Dst  in  5  destination register of instruction in EX
ID_MulDivStart  in  1  ID instruction is MULT/MULTU/DIV/DIVU
ID_HiLoAccess  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO or mult/div
ID_Eret  in  1  ID instruction is ERET
EX_BLCancel  in  1  branch-likely in EX not taken; cancel delay slot
MEM_Exception  in  1  instruction in MEM raised an exception
IF_MemBusy  in  1  instruction memory not ready
MEM_MemBusy  in  1  data memory not ready
IF_Stall  out  1  hold PC / zero instruction into ID
ID_Stall  out  1  hold IF/ID register
EX_Stall  out  1  hold ID/EX register
MEM_Stall  out  1  hold EX/MEM register
IF_Flush  out  1  zero instruction entering ID
ID_Flush  out  1  insert bubble into EX
EX_Flush  out  1  insert bubble into MEM
PC_SelVector  out  1  PC loads exception vector this cycle
MulDivBusy  out  1  mult/div counter nonzero
StallCount  out  32  ID stall cycles (see Optional Feature)

Behaviour:
- Reset (RST_N=0, async):
  - state=RUN, counter=0.
  - All outputs 0 combinationally while reset is asserted; StallCount=0.
- Load-use hazard (comb): LU = EX_MemRead & EX_Dst!=0 & ((ID_UsesRs & ID_Rs==EX_Dst) | (ID_UsesRt & ID_Rt==EX_Dst)).
- HI/LO hazard (comb): HL = ID_HiLoAccess & MulDivBusy.
- Stall chain in RUN, no exception:
  - MEM_Stall = MEM_MemBusy
  - EX_Stall = MEM_Stall
  - ID_Stall = EX_Stall | LU | HL
  - IF_Stall = ID_Stall | IF_MemBusy
- ID_Flush = ID_Stall & ~EX_Stall: bubble, so a stalled ID never duplicates into EX.
- IF_Flush = EX_BLCancel | (ID_Eret & ~ID_Stall): the delay slot is squashed.
- Mult/div counter:
  - Loads MULDIV_CYCLES on ID_MulDivStart & ~ID_Stall & state==RUN & ~MEM_Exception.
  - Otherwise decrements when nonzero; saturates at 0.
  - MulDivBusy = (counter!=0), registered value.
  - A start while busy is stalled by HL, so it is never lost.
  - The counter is not cleared by an exception: the issued op completes.
- Exception FSM, states RUN and EXC_HOLD:
  - RUN & MEM_Exception & ~MEM_MemBusy, same cycle:
    - PC_SelVector=1, IF_Flush=ID_Flush=EX_Flush=1.
    - ID_Stall=EX_Stall=MEM_Stall=0.
    - IF_Stall=IF_MemBusy.
    - Next state EXC_HOLD.
  - RUN & MEM_Exception & MEM_MemBusy: normal stall; the exception is taken when busy drops.
  - EXC_HOLD:
    - IF_Flush=1 (squash the fetch from the old PC).
    - Other flushes 0; stalls per chain.
    - Returns to RUN on the first cycle IF_MemBusy=0.
  - MEM_Exception in EXC_HOLD is ignored; the pipeline is already flushed.
- Priority: exception > memory stall > LU/HL > ERET/BL flush.
  - EX_BLCancel while IF_Stall: IF_Flush still 1.
- All outputs except MulDivBusy, StallCount and the state are combinational; zero latency.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: StallCount is a 32-bit register, +1 each cycle ID_Stall=1; saturates at 32'hFFFFFFFF; cleared by reset.
- Undefined: no counter logic; StallCount tied to 0.

Test Plan:
- Load-use: EX_MemRead=1, EX_Dst=5, ID_Rs=5, ID_UsesRs=1 for 1 cycle -> ID_Stall=IF_Stall=ID_Flush=1 that cycle, EX_Stall=0.
- EX_Dst=0 with same setup -> no stall.
- Mult/div, MULDIV_CYCLES=4: ID_MulDivStart=1 at cycle 0 -> MulDivBusy=1 cycles 1-4, 0 at cycle 5.
  - MFLO (ID_HiLoAccess=1) at cycle 2 -> ID_Stall=1 cycles 2-4, released at cycle 5.
- Exception: MEM_Exception=1, MEM_MemBusy=0 -> same cycle PC_SelVector=1, IF/ID/EX_Flush=1.
  - Next cycle with IF_MemBusy=1 for 2 cycles -> IF_Flush=1 for 2 cycles, then RUN.
- Memory stall: MEM_MemBusy=1 for 3 cycles -> MEM/EX/ID/IF_Stall=1, ID_Flush=0 for 3 cycles.
  - MEM_Exception held throughout -> PC_SelVector=1 only on the cycle busy drops.
- ERET: ID_Eret=1, no stall -> IF_Flush=1.
- EX_BLCancel=1 with IF_MemBusy=1 -> IF_Flush=1, IF_Stall=1.
- Reset mid-op: counter=3, EXC_HOLD, RST_N=0 asynchronously -> MulDivBusy=0 and all outputs 0 immediately; state RUN after release.
